ball_dynamics: RTL

- Parametrised successor to the Pong game-dynamics block.
- Advances the ball once per frame tick (dyn_clk), resolving wall, paddle and goal events.
- Adds a serve/play/pause/goal state machine, zone-based paddle deflection, rally speed-up and a sound-event timer.
- Sits between the player-position inputs and the renderer, scoreboard and sound generator.

---
 rtl/ball_dynamics.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ball_dynamics.sv
// ball_dynamics: frame-rate Pong ball engine with a serve/play/pause/goal FSM, paddle zone deflection,
// rally speed-up and a sound-event timer. Define DYN_SPIN_EN to add paddle-motion spin on speed_y.
module ball_dynamics #(
    parameter int SCREEN_W      = 800,
    parameter int SCREEN_H      = 600,
    parameter int BALL_SIZE     = 10,
    parameter int PAD_H         = 80,
    parameter int PAD_W         = 10,
    parameter int PAD_OFFSET    = 20,
    parameter int POS_W         = 10,
    parameter int SPEED_W       = 3,
    parameter int SPEED_INIT    = 2,
    parameter int SPEED_MAX     = 6,
    parameter int HITS_PER_STEP = 4,
    parameter int GOAL_WAIT     = 60,
    parameter int SND_WALL      = 10,
    parameter int SND_PAD       = 30,
    parameter int SND_GOAL      = 40
) (
    input  logic               dyn_clk,
    input  logic               reset_n,
    input  logic               new_game,
    input  logic               play,
    input  logic [POS_W-1:0]   pos_ply1,
    input  logic [POS_W-1:0]   pos_ply2,
    output logic               reset_goals,
    output logic               goal_ply1,
    output logic               goal_ply2,
    output logic [POS_W-1:0]   x_ball,
    output logic [POS_W-1:0]   y_ball,
    output logic [SPEED_W-1:0] speed_x,
    output logic [1:0]         state,
    output logic               mute,
    output logic [1:0]         sound
);

    localparam int CW       = POS_W + 2;
    localparam int HW       = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP) : 1;
    localparam int GW       = (GOAL_WAIT > 1) ? $clog2(GOAL_WAIT) : 1;
    localparam int SND_MAXD = (SND_GOAL > SND_PAD) ? ((SND_GOAL > SND_WALL) ? SND_GOAL : SND_WALL)
                                                   : ((SND_PAD > SND_WALL) ? SND_PAD : SND_WALL);
    localparam int TW       = $clog2(SND_MAXD + 1);

    localparam logic signed [CW-1:0] C_ZERO  = '0;
    localparam logic signed [CW-1:0] C_BALL  = CW'(BALL_SIZE);
    localparam logic signed [CW-1:0] C_HALF  = CW'(BALL_SIZE / 2);
    localparam logic signed [CW-1:0] C_PADH  = CW'(PAD_H);
    localparam logic signed [CW-1:0] C_QTR   = CW'(PAD_H / 4);
    localparam logic signed [CW-1:0] C_Q3    = CW'(PAD_H - PAD_H / 4);
    localparam logic signed [CW-1:0] C_OFF   = CW'(PAD_OFFSET);
    localparam logic signed [CW-1:0] C_FACE1 = CW'(PAD_OFFSET + PAD_W);
    localparam logic signed [CW-1:0] C_X2HIT = CW'(SCREEN_W - PAD_OFFSET - PAD_W - BALL_SIZE);
    localparam logic signed [CW-1:0] C_X2LIM = CW'(SCREEN_W - PAD_OFFSET - BALL_SIZE);
    localparam logic signed [CW-1:0] C_XMAX  = CW'(SCREEN_W - BALL_SIZE);
    localparam logic signed [CW-1:0] C_YMAX  = CW'(SCREEN_H - BALL_SIZE);

    localparam logic [POS_W-1:0]   X_CTR = POS_W'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [POS_W-1:0]   Y_CTR = POS_W'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [SPEED_W-1:0] S_INI = SPEED_W'(SPEED_INIT);

    typedef enum logic [1:0] {S_SERVE = 2'd0, S_PLAY = 2'd1, S_PAUSE = 2'd2, S_GOAL = 2'd3} state_t;
    typedef enum logic [1:0] {EV_NONE = 2'd0, EV_WALL = 2'd1, EV_PAD = 2'd2, EV_GOAL = 2'd3} event_t;

    state_t             st_q, st_d;
    event_t             snd_q, snd_d, ev;
    logic [POS_W-1:0]   x_q, x_d, y_q, y_d;
    logic               dx_q, dx_d, dy_q, dy_d;
    logic [SPEED_W-1:0] sx_q, sx_d, sy_q, sy_d, sy_h;
    logic [HW-1:0]      hits_q, hits_d;
    logic [GW-1:0]      gcnt_q, gcnt_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic               mute_d, g1_d, g2_d, rg_d, dy_h, wall, recentre;

    logic signed [CW-1:0] xs, ys, sxs, sy_hs, p1s, p2s, rel;
    logic                 hit1, hit2, zone_top, zone_bot;

    function automatic logic [SPEED_W-1:0] spd_up(input logic [SPEED_W-1:0] v);
        return (v >= SPEED_W'(SPEED_MAX)) ? v : v + 1'b1;
    endfunction

    function automatic logic [SPEED_W-1:0] spd_dn(input logic [SPEED_W-1:0] v);
        return (v <= SPEED_W'(1)) ? SPEED_W'(1) : v - 1'b1;
    endfunction

    // All geometry is compared in signed POS_W+2 bits so x-speed and y+size cannot wrap.
    assign xs  = $signed({2'b00, x_q});
    assign ys  = $signed({2'b00, y_q});
    assign p1s = $signed({2'b00, pos_ply1});
    assign p2s = $signed({2'b00, pos_ply2});
    assign sxs = $signed({{(CW-SPEED_W){1'b0}}, sx_q});

    assign hit1 = !dx_q && (xs - sxs <= C_FACE1) && (xs >= C_OFF)
                  && (ys + C_BALL > p1s) && (ys < p1s + C_PADH);
    assign hit2 = dx_q && (xs + sxs >= C_X2HIT) && (xs <= C_X2LIM)
                  && (ys + C_BALL > p2s) && (ys < p2s + C_PADH);

    assign rel      = ys + C_HALF - (hit1 ? p1s : p2s);
    assign zone_top = rel < C_QTR;
    assign zone_bot = rel >= C_Q3;

`ifdef DYN_SPIN_EN
    logic [POS_W-1:0] prev1_q, prev2_q;
    logic             pad_dn, pad_up;

    assign pad_dn = hit1 ? (pos_ply1 > prev1_q) : (pos_ply2 > prev2_q);
    assign pad_up = hit1 ? (pos_ply1 < prev1_q) : (pos_ply2 < prev2_q);

    always_ff @(posedge dyn_clk or negedge reset_n) begin
        if (!reset_n) begin
            prev1_q <= '0;
            prev2_q <= '0;
        end else begin
            prev1_q <= pos_ply1;
            prev2_q <= pos_ply2;
        end
    end
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        st_d     = st_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        hits_d   = hits_q;
        gcnt_d   = gcnt_q;
        ev       = EV_NONE;
        g1_d     = 1'b0;
        g2_d     = 1'b0;
        rg_d     = 1'b0;
        recentre = 1'b0;
        wall     = 1'b0;
        dy_h     = dy_q;
        sy_h     = sy_q;
        sy_hs    = '0;

        if (new_game) begin
            rg_d     = 1'b1;
            recentre = 1'b1;
            st_d     = S_SERVE;
            gcnt_d   = '0;
        end else begin
            unique case (st_q)
                S_SERVE, S_PAUSE: if (play) st_d = S_PLAY;
                S_GOAL: begin
                    if (gcnt_q == GW'(GOAL_WAIT - 1)) begin
                        recentre = 1'b1;
                        st_d     = S_SERVE;
                        gcnt_d   = '0;
                    end else begin
                        gcnt_d = gcnt_q + 1'b1;
                    end
                end
                S_PLAY: begin
                    if (play) begin
                        st_d = S_PAUSE;
                    end else begin
                        if (hit1 || hit2) begin
                            if (zone_top) begin
                                dy_h = 1'b0;
                                sy_h = spd_up(sy_q);
                            end else if (zone_bot) begin
                                dy_h = 1'b1;
                                sy_h = spd_up(sy_q);
                            end else begin
                                sy_h = spd_dn(sy_q);
                            end
`ifdef DYN_SPIN_EN
                            if ((dy_h && pad_dn) || (!dy_h && pad_up))
                                sy_h = spd_up(sy_h);
                            else if ((dy_h && pad_up) || (!dy_h && pad_dn))
                                sy_h = spd_dn(sy_h);
`endif
                            x_d  = hit1 ? POS_W'(PAD_OFFSET + PAD_W)
                                        : POS_W'(SCREEN_W - PAD_OFFSET - PAD_W - BALL_SIZE);
                            dx_d = hit1;
                            if (hits_q == HW'(HITS_PER_STEP - 1)) begin
                                hits_d = '0;
                                sx_d   = spd_up(sx_q);
                            end else begin
                                hits_d = hits_q + 1'b1;
                            end
                            ev = EV_PAD;
                        end else if (xs - sxs <= C_ZERO) begin
                            x_d    = '0;
                            dx_d   = 1'b0;
                            g2_d   = 1'b1;
                            st_d   = S_GOAL;
                            gcnt_d = '0;
                            ev     = EV_GOAL;
                        end else if (xs + sxs >= C_XMAX) begin
                            x_d    = POS_W'(SCREEN_W - BALL_SIZE);
                            dx_d   = 1'b1;
                            g1_d   = 1'b1;
                            st_d   = S_GOAL;
                            gcnt_d = '0;
                            ev     = EV_GOAL;
                        end else begin
                            x_d = dx_q ? x_q + POS_W'(sx_q) : x_q - POS_W'(sx_q);
                        end

                        // The y axis moves with the direction and speed a paddle just imposed.
                        sy_hs = $signed({{(CW-SPEED_W){1'b0}}, sy_h});
                        sy_d  = sy_h;
                        if (!dy_h && (ys <= sy_hs)) begin
                            y_d  = '0;
                            dy_d = 1'b1;
                            wall = 1'b1;
                        end else if (dy_h && (ys + sy_hs >= C_YMAX)) begin
                            y_d  = POS_W'(SCREEN_H - BALL_SIZE);
                            dy_d = 1'b0;
                            wall = 1'b1;
                        end else begin
                            y_d  = dy_h ? y_q + POS_W'(sy_h) : y_q - POS_W'(sy_h);
                            dy_d = dy_h;
                        end
                        if (wall && (ev == EV_NONE)) ev = EV_WALL;
                    end
                end
                default: st_d = S_SERVE;
            endcase
        end

        if (recentre) begin
            x_d    = X_CTR;
            y_d    = Y_CTR;
            sx_d   = S_INI;
            sy_d   = S_INI;
            hits_d = '0;
        end

        tmr_d = tmr_q;
        snd_d = snd_q;
        if (st_q != S_PAUSE) begin
            if (ev != EV_NONE) begin
                snd_d = ev;
                tmr_d = (ev == EV_GOAL) ? TW'(SND_GOAL) : (ev == EV_PAD) ? TW'(SND_PAD) : TW'(SND_WALL);
            end else if (tmr_q != '0) begin
                tmr_d = tmr_q - 1'b1;
            end
        end
        if (tmr_d == '0) snd_d = EV_NONE;
        mute_d = (st_d == S_PAUSE) || (tmr_d == '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge dyn_clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q        <= S_SERVE;
            x_q         <= X_CTR;
            y_q         <= Y_CTR;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            sx_q        <= S_INI;
            sy_q        <= S_INI;
            hits_q      <= '0;
            gcnt_q      <= '0;
            tmr_q       <= '0;
            snd_q       <= EV_NONE;
            mute        <= 1'b1;
            goal_ply1   <= 1'b0;
            goal_ply2   <= 1'b0;
            reset_goals <= 1'b0;
        end else begin
            st_q        <= st_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            hits_q      <= hits_d;
            gcnt_q      <= gcnt_d;
            tmr_q       <= tmr_d;
            snd_q       <= snd_d;
            mute        <= mute_d;
            goal_ply1   <= g1_d;
            goal_ply2   <= g2_d;
            reset_goals <= rg_d;
        end
    end

    assign x_ball  = x_q;
    assign y_ball  = y_q;
    assign speed_x = sx_q;
    assign state   = st_q;
    assign sound   = snd_q;

endmodule
